// File: rtl/mk_seq_pkg.sv
// Shared types and control-word layout for the microprogram sequencer and its control store.
package mk_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StExec,
    StEval,
    StWait,
    StDone,
    StErr
  } mk_state_t;

  localparam int unsigned COND_NONE = 0;

  // Control-word bit offsets, LSB first, for the default AW=5 / CSW=3 layout.
  localparam int unsigned CW_END_LSB    = 0;
  localparam int unsigned CW_INV_LSB    = 1;
  localparam int unsigned CW_SEL_LSB    = 2;
  localparam int unsigned CW_BRANCH_LSB = 5;
  localparam int unsigned CW_NEXT_LSB   = 10;
  localparam int unsigned CW_WIDTH      = 15;

endpackage

// File: rtl/mk_next_addr.sv
// Combinational branch resolution: picks the branch target or the sequential next address.
module mk_next_addr
  import mk_seq_pkg::*;
#(
  parameter int unsigned AW    = 5,
  parameter int unsigned NCOND = 8,
  parameter int unsigned CSW   = 3
) (
  input  logic [NCOND-1:0] cond,
  input  logic [CSW-1:0]   cond_sel,
  input  logic             cond_inv,
  input  logic [AW-1:0]    mk_next,
  input  logic [AW-1:0]    mk_branch,
  output logic [AW-1:0]    next_addr,
  output logic             take
);

  logic sel_bit;
  logic sel_valid;

  always_comb begin
    sel_bit = 1'b0;
    for (int unsigned k = 0; k < NCOND; k++) begin
      if (32'(cond_sel) == k) sel_bit = cond[k];
    end
    // Selects beyond the implemented flags must not branch even when inverted.
    sel_valid = (32'(cond_sel) != COND_NONE) && (32'(cond_sel) < NCOND);
    take      = sel_valid && (sel_bit ^ cond_inv);
    next_addr = take ? mk_branch : mk_next;
  end

endmodule

// File: rtl/mk_sequencer.sv
// Microprogram sequencer: owns the micro-address, issues one execute strobe per
// micro-instruction, resolves branches, and supports run, single-step, abort and a watchdog.
module mk_sequencer
  import mk_seq_pkg::*;
#(
  parameter int unsigned AW         = 5,
  parameter int unsigned NCOND      = 8,
  parameter int unsigned CSW        = 3,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned WDOG       = 200,
  parameter int unsigned CNTW       = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             step_mode,
  input  logic             step,
  input  logic             abort,
  input  logic [AW-1:0]    mk_next,
  input  logic [AW-1:0]    mk_branch,
  input  logic [CSW-1:0]   cond_sel,
  input  logic             cond_inv,
  input  logic             end_flag,
  input  logic [NCOND-1:0] cond,
  output logic [AW-1:0]    mk_addr,
  output logic             mk_en,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNTW-1:0]  uinstr_cnt
);

  mk_state_t     state;
  logic [AW-1:0] next_addr;
  logic          take;

  mk_next_addr #(
    .AW   (AW),
    .NCOND(NCOND),
    .CSW  (CSW)
  ) u_next_addr (
    .cond     (cond),
    .cond_sel (cond_sel),
    .cond_inv (cond_inv),
    .mk_next  (mk_next),
    .mk_branch(mk_branch),
    .next_addr(next_addr),
    .take     (take)
  );

  // mk_en, busy, done and err are registered alongside the state they describe.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= StIdle;
      mk_addr    <= AW'(START_ADDR);
      mk_en      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      uinstr_cnt <= '0;
    end else begin
      mk_en <= 1'b0;
      done  <= 1'b0;
      unique case (state)
        StIdle, StErr: begin
          if (start && !abort) begin
            state      <= StExec;
            mk_addr    <= AW'(START_ADDR);
            uinstr_cnt <= '0;
            err        <= 1'b0;
            mk_en      <= 1'b1;
            busy       <= 1'b1;
          end
        end
        StExec: begin
          // The strobe of this cycle is committed, so it is counted even on abort.
          if (uinstr_cnt != {CNTW{1'b1}}) uinstr_cnt <= uinstr_cnt + 1'b1;
          if (abort) begin
            state   <= StIdle;
            mk_addr <= AW'(START_ADDR);
            busy    <= 1'b0;
          end else begin
            state <= StEval;
          end
        end
        StEval: begin
          if (abort) begin
            state   <= StIdle;
            mk_addr <= AW'(START_ADDR);
            busy    <= 1'b0;
          end else if (end_flag) begin
            state <= StDone;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            mk_addr <= next_addr;
            if (32'(uinstr_cnt) >= WDOG) begin
              state <= StErr;
              err   <= 1'b1;
              busy  <= 1'b0;
            end else if (step_mode) begin
              state <= StWait;
            end else begin
              state <= StExec;
              mk_en <= 1'b1;
            end
          end
        end
        StWait: begin
          if (abort) begin
            state   <= StIdle;
            mk_addr <= AW'(START_ADDR);
            busy    <= 1'b0;
          end else if (step || !step_mode) begin
            state <= StExec;
            mk_en <= 1'b1;
          end
        end
        StDone: state <= StIdle;
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assert property (@(posedge clock) disable iff (reset) take |-> (next_addr == mk_branch));

endmodule
